// File: rtl/hv_dac_sequencer.sv
// -----------------------------------------------------------------------------
// hv_dac_sequencer
//
// Ramps a high-voltage DAC code toward a clamped target at a programmable
// rate. It also sequences I2C writes that refresh the threshold DACs and the
// HV DAC. A full sweep (threshold slots 0..NCH-1, then the HV slot) runs on
// every refresh-counter expiry. Between sweeps, any change of the ramped HV
// code triggers a write to the HV slot only.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        asynchronous, active-low reset
//   hv_enable    ramp toward target when high, toward 0 when low
//   hv_target    requested HV code
//   hv_limit     hard ceiling on the HV code
//   ramp_period  cycles per 1-LSB ramp step (0 behaves as 1)
//   thresholds   packed threshold codes, channel k at [k*DW +: DW]
//   eeprom_sel   DAC command / EEPROM select bits
//   i2c_busy     I2C engine busy; a request is held off while it is high
//   i2c_done     I2C engine completion pulse (1 cycle)
//   i2c_start    1-cycle transaction request
//   i2c_line     bus select: 2 = threshold bus, 1 = HV bus
//   i2c_data12   bytes 1-2 of the write (command + select bits)
//   i2c_data34   bytes 3-4 of the write (DAC code, MSB aligned)
//   hv_current   present ramped HV code
//   at_target    hv_current equals the effective target
//   err_timeout  sticky: some transaction never reported done
// -----------------------------------------------------------------------------
module hv_dac_sequencer #(
    parameter int NCH     = 2,
    parameter int DW      = 12,
    parameter int HV_INIT = 0,
    parameter int REFRESH = 4194304,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hv_enable,
    input  logic [DW-1:0]     hv_target,
    input  logic [DW-1:0]     hv_limit,
    input  logic [15:0]       ramp_period,
    input  logic [NCH*DW-1:0] thresholds,
    input  logic [2:0]        eeprom_sel,
    input  logic              i2c_busy,
    input  logic              i2c_done,
    output logic              i2c_start,
    output logic [1:0]        i2c_line,
    output logic [15:0]       i2c_data12,
    output logic [15:0]       i2c_data34,
    output logic [DW-1:0]     hv_current,
    output logic              at_target,
    output logic              err_timeout
);

    // Slot index must reach NCH (the HV slot).
    localparam int SW = $clog2(NCH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_NEXT
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] slot_reg;
    logic          sweep_reg;
    logic [DW-1:0] hv_reg;
    logic          hv_dirty_reg;
    logic          pending_reg;
    logic [15:0]   tick_cnt_reg;
    logic [31:0]   ref_cnt_reg;
    logic [31:0]   wait_cnt_reg;
    logic [1:0]    line_reg;
    logic [15:0]   data12_reg;
    logic [15:0]   data34_reg;
    logic          err_reg;

    // FSM strobes
    logic start_sweep;
    logic start_hv;
    logic do_load;
    logic timeout_hit;
    logic advance;

    // ------------------------------------------------------------------
    // Ramp datapath
    // ------------------------------------------------------------------
    logic [DW-1:0] eff_target;
    logic [15:0]   period_eff;
    logic          tick;
    logic          hv_up;
    logic          hv_dn;

    assign eff_target = !hv_enable            ? '0 :
                        (hv_target < hv_limit) ? hv_target : hv_limit;
    assign period_eff = (ramp_period == 16'd0) ? 16'd1 : ramp_period;
    // ">=" rather than "==" so that shortening ramp_period below the
    // current count fires a tick at once instead of waiting for a wrap.
    assign tick       = (tick_cnt_reg >= (period_eff - 16'd1));
    // A code above a lowered hv_limit simply becomes a ramp-down, since
    // eff_target never exceeds hv_limit.
    assign hv_up      = tick && (hv_reg < eff_target);
    assign hv_dn      = tick && (hv_reg > eff_target);

    logic ref_expiry;
    assign ref_expiry = (ref_cnt_reg == 32'(REFRESH - 1));

    // ------------------------------------------------------------------
    // Threshold channel unpacking, padded to a power of two so that any
    // slot value indexes a defined entry (the HV slot reads zero here and
    // is never selected for a threshold write anyway).
    // ------------------------------------------------------------------
    logic [DW-1:0] thr_arr [2**SW];

    generate
        for (genvar gi = 0; gi < 2**SW; gi++) begin : g_thr
            if (gi < NCH) begin : g_used
                assign thr_arr[gi] = thresholds[gi*DW +: DW];
            end else begin : g_pad
                assign thr_arr[gi] = '0;
            end
        end
    endgenerate

    // Transaction contents for the current slot; codes are MSB aligned.
    logic [1:0]  load_line;
    logic [15:0] load_data12;
    logic [15:0] load_data34;
    logic [7:0]  slot_cmd;

    always_comb begin
        slot_cmd    = 8'hC0 + (8'(slot_reg) << 1);
        load_line   = 2'd1;
        load_data12 = {8'hC0, eeprom_sel, 5'b0};
        load_data34 = 16'(hv_reg) << (16 - DW);
        if (slot_reg < SW'(NCH)) begin
            load_line   = 2'd2;
            load_data12 = {slot_cmd, eeprom_sel, 5'b0};
            load_data34 = 16'(thr_arr[slot_reg]) << (16 - DW);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        i2c_start   = 1'b0;
        start_sweep = 1'b0;
        start_hv    = 1'b0;
        do_load     = 1'b0;
        timeout_hit = 1'b0;
        advance     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A refresh (now or held over) wins over an HV-only update;
                // the sweep rewrites the HV slot anyway.
                if (ref_expiry || pending_reg) begin
                    start_sweep = 1'b1;
                    state_next  = ST_LOAD;
                end else if (hv_dirty_reg) begin
                    start_hv   = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                do_load    = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                if (!i2c_busy) begin
                    i2c_start  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    state_next = ST_NEXT;
                end else if (wait_cnt_reg >= 32'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (sweep_reg && (slot_reg < SW'(NCH))) begin
                    advance    = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slot_reg     <= '0;
            sweep_reg    <= 1'b0;
            hv_reg       <= DW'(HV_INIT);
            hv_dirty_reg <= 1'b0;
            pending_reg  <= 1'b0;
            tick_cnt_reg <= '0;
            ref_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            line_reg     <= '0;
            data12_reg   <= '0;
            data34_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            tick_cnt_reg <= tick ? 16'd0 : tick_cnt_reg + 16'd1;
            ref_cnt_reg  <= ref_expiry ? 32'd0 : ref_cnt_reg + 32'd1;

            if (hv_up) begin
                hv_reg <= hv_reg + DW'(1);
            end else if (hv_dn) begin
                hv_reg <= hv_reg - DW'(1);
            end

            // A step in the same cycle as the HV load must survive: the
            // load captured the pre-step code, so another write is owed.
            if (hv_up || hv_dn) begin
                hv_dirty_reg <= 1'b1;
            end else if (do_load && (slot_reg == SW'(NCH))) begin
                hv_dirty_reg <= 1'b0;
            end

            // Expiries arriving mid-transaction are remembered for IDLE.
            pending_reg <= start_sweep ? 1'b0 : (pending_reg | ref_expiry);

            if (start_sweep) begin
                slot_reg  <= '0;
                sweep_reg <= 1'b1;
            end else if (start_hv) begin
                slot_reg  <= SW'(NCH);
                sweep_reg <= 1'b0;
            end else if (advance) begin
                slot_reg  <= slot_reg + SW'(1);
            end

            if (do_load) begin
                line_reg   <= load_line;
                data12_reg <= load_data12;
                data34_reg <= load_data34;
            end

            // The start cycle itself counts toward the timeout.
            if (i2c_start) begin
                wait_cnt_reg <= 32'd1;
            end else if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end

            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign i2c_line    = line_reg;
    assign i2c_data12  = data12_reg;
    assign i2c_data34  = data34_reg;
    assign hv_current  = hv_reg;
    assign at_target   = (hv_reg == eff_target);
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_hv_dac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hv_dac_sequencer
//
// Directed plus randomized stimulus for hv_dac_sequencer. A cycle-level ramp
// model tracks the expected HV code from the rules: one step toward
// min(target, limit) every max(period, 1) cycles. The bench also contains a
// small I2C engine that answers each start with done after a fixed delay, or
// never answers. Every start is recorded with its cycle number, bus line and
// data words, so that expected sweep contents can be computed directly from
// the applied inputs.
// -----------------------------------------------------------------------------
module tb_hv_dac_sequencer;

    localparam int NCH      = 2;
    localparam int DW       = 12;
    localparam int HV_INIT  = 0;
    localparam int REFRESH  = 300;
    localparam int TIMEOUT  = 100;
    localparam int DONE_DLY = 10;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              hv_enable;
    logic [DW-1:0]     hv_target;
    logic [DW-1:0]     hv_limit;
    logic [15:0]       ramp_period;
    logic [NCH*DW-1:0] thresholds;
    logic [2:0]        eeprom_sel;
    logic              i2c_busy;
    logic              i2c_done;
    logic              i2c_start;
    logic [1:0]        i2c_line;
    logic [15:0]       i2c_data12;
    logic [15:0]       i2c_data34;
    logic [DW-1:0]     hv_current;
    logic              at_target;
    logic              err_timeout;

    hv_dac_sequencer #(
        .NCH     (NCH),
        .DW      (DW),
        .HV_INIT (HV_INIT),
        .REFRESH (REFRESH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hv_enable   (hv_enable),
        .hv_target   (hv_target),
        .hv_limit    (hv_limit),
        .ramp_period (ramp_period),
        .thresholds  (thresholds),
        .eeprom_sel  (eeprom_sel),
        .i2c_busy    (i2c_busy),
        .i2c_done    (i2c_done),
        .i2c_start   (i2c_start),
        .i2c_line    (i2c_line),
        .i2c_data12  (i2c_data12),
        .i2c_data34  (i2c_data34),
        .hv_current  (hv_current),
        .at_target   (at_target),
        .err_timeout (err_timeout)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int m_hv  = HV_INIT;
    int m_since = 0;
    bit prev_start = 0;
    int done_cnt = 0;
    bit eng_answers = 1;

    int q_cyc[$];
    int q_line[$];
    int q_d12[$];
    int q_d34[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_now();
        if (!hv_enable) return 0;
        return (hv_target < hv_limit) ? int'(hv_target) : int'(hv_limit);
    endfunction

    function automatic int exp_d12(input int slot, input int sel);
        return ((8'hC0 + 2 * slot) << 8) | (sel << 5);
    endfunction

    function automatic int exp_d34(input int code);
        return (code << (16 - DW)) & 16'hFFFF;
    endfunction

    function automatic int ramp_step(input int cur, input int tgt);
        if (cur < tgt) return cur + 1;
        if (cur > tgt) return cur - 1;
        return cur;
    endfunction

    task automatic clear_log();
        q_cyc.delete();
        q_line.delete();
        q_d12.delete();
        q_d34.delete();
    endtask

    // One clock cycle: observe the end of the current cycle, advance the
    // model across the edge, then check the ramp just after the edge.
    task automatic cyc();
        int p;
        #2;
        if (i2c_start === 1'b1) begin
            chk("start_width", 32'(prev_start), 32'd0);
            q_cyc.push_back(cyc_n);
            q_line.push_back(int'(i2c_line));
            q_d12.push_back(int'(i2c_data12));
            q_d34.push_back(int'(i2c_data34));
            $display("start cycle=%0d line=%0d data12=0x%04h data34=0x%04h hv=%0d",
                     cyc_n, i2c_line, i2c_data12, i2c_data34, hv_current);
            if (eng_answers) done_cnt = DONE_DLY;
        end
        prev_start = (i2c_start === 1'b1);
        @(posedge clk_i);
        if (!rst_i) begin
            m_hv    = HV_INIT;
            m_since = 0;
        end else begin
            p = (ramp_period == 16'd0) ? 1 : int'(ramp_period);
            m_since++;
            if (m_since >= p) begin
                m_since = 0;
                m_hv    = ramp_step(m_hv, eff_now());
            end
        end
        #1;
        cyc_n++;
        i2c_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) i2c_done = 1'b1;
        end
        if (rst_i) begin
            chk("hv_current", 32'(hv_current), 32'(m_hv));
            chk("at_target", 32'(at_target), 32'(m_hv == eff_now()));
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (q_cyc.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk("start_count", 32'(q_cyc.size()), 32'(n));
    endtask

    // Park in the middle of the refresh interval, where no sweep runs.
    task automatic align_mid();
        while (cyc_n % REFRESH != REFRESH / 2) cyc();
    endtask

    task automatic wait_hv(input int code);
        int k = 0;
        while (m_hv != code && k < 5000) begin
            cyc();
            k++;
        end
        repeat (60) cyc();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hv"},    32'(hv_current),  32'(HV_INIT));
        chk({tag, "_start"}, 32'(i2c_start),   32'd0);
        chk({tag, "_line"},  32'(i2c_line),    32'd0);
        chk({tag, "_d12"},   32'(i2c_data12),  32'd0);
        chk({tag, "_d34"},   32'(i2c_data34),  32'd0);
        chk({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    task automatic check_sweep(input int t0, input int t1, input int sel, input int hv);
        clear_log();
        wait_starts(3, 2 * REFRESH + 100);
        if (q_cyc.size() >= 3) begin
            chk("sweep_latency", 32'(q_cyc[0] % REFRESH), 32'd1);
            chk("sweep_line0", 32'(q_line[0]), 32'd2);
            chk("sweep_line1", 32'(q_line[1]), 32'd2);
            chk("sweep_line2", 32'(q_line[2]), 32'd1);
            chk("sweep_d12_0", 32'(q_d12[0]), 32'(exp_d12(0, sel)));
            chk("sweep_d12_1", 32'(q_d12[1]), 32'(exp_d12(1, sel)));
            chk("sweep_d12_2", 32'(q_d12[2]), 32'(exp_d12(0, sel)));
            chk("sweep_d34_0", 32'(q_d34[0]), 32'(exp_d34(t0)));
            chk("sweep_d34_1", 32'(q_d34[1]), 32'(exp_d34(t1)));
            chk("sweep_d34_2", 32'(q_d34[2]), 32'(exp_d34(hv)));
        end
    endtask

    initial begin
        int s, nb, t0, t1, sel, r;

        // ---------------- reset and ramp-up ----------------
        rst_i       = 1'b0;
        hv_enable   = 1'b1;
        hv_target   = 12'd10;
        hv_limit    = 12'd4000;
        ramp_period = 16'd4;
        thresholds  = '0;
        eeprom_sel  = 3'd0;
        i2c_busy    = 1'b0;
        i2c_done    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_i = 1'b1;
        cyc_n = 0;

        repeat (39) cyc();
        chk("ramp_before_end", 32'(hv_current), 32'd9);
        cyc();
        chk("ramp_end", 32'(hv_current), 32'd10);
        chk("ramp_at_target", 32'(at_target), 32'd1);
        repeat (20) cyc();
        chk("ramp_hold", 32'(hv_current), 32'd10);

        // ---------------- clamp and lowered limit ----------------
        hv_target   = 12'd3000;
        hv_limit    = 12'd2000;
        ramp_period = 16'd1;
        repeat (2100) cyc();
        chk("clamp", 32'(hv_current), 32'd2000);
        hv_limit    = 12'd1990;
        ramp_period = 16'd3;
        repeat (15) cyc();
        chk("limit_step_mid", 32'(hv_current), 32'd1995);
        repeat (15) cyc();
        chk("limit_step_end", 32'(hv_current), 32'd1990);
        repeat (10) cyc();
        chk("limit_hold", 32'(hv_current), 32'd1990);

        // ---------------- randomized ramp settings ----------------
        for (int i = 0; i < 6; i++) begin
            hv_enable   = ($urandom_range(0, 3) != 0);
            hv_target   = DW'($urandom);
            hv_limit    = DW'($urandom);
            ramp_period = 16'($urandom_range(0, 6));
            repeat (120) cyc();
        end

        // ---------------- directed sweep ----------------
        hv_enable   = 1'b1;
        hv_target   = 12'd500;
        hv_limit    = 12'd4095;
        ramp_period = 16'd1;
        thresholds  = {12'd4000, 12'd2100};
        eeprom_sel  = 3'd3;
        wait_hv(500);
        align_mid();
        check_sweep(2100, 4000, 3, 500);

        // ---------------- randomized sweep ----------------
        t0  = int'($urandom_range(0, 4095));
        t1  = int'($urandom_range(0, 4095));
        sel = int'($urandom_range(0, 7));
        r   = int'($urandom_range(1, 4095));
        thresholds = {DW'(t1), DW'(t0)};
        eeprom_sel = 3'(sel);
        hv_target  = DW'(r);
        wait_hv(r);
        align_mid();
        check_sweep(t0, t1, sel, r);

        // ---------------- timeout ----------------
        align_mid();
        chk("err_clear_before", 32'(err_timeout), 32'd0);
        eng_answers = 0;
        clear_log();
        wait_starts(1, REFRESH + 20);
        s = (q_cyc.size() > 0) ? q_cyc[0] : cyc_n;
        while (cyc_n < s + TIMEOUT - 1) cyc();
        chk("err_before_timeout", 32'(err_timeout), 32'd0);
        cyc();
        chk("err_at_timeout", 32'(err_timeout), 32'd1);
        wait_starts(2, 30);
        if (q_cyc.size() >= 2) begin
            chk("after_timeout_line", 32'(q_line[1]), 32'd2);
            chk("after_timeout_d12", 32'(q_d12[1]), 32'(exp_d12(1, sel)));
        end
        wait_starts(3, 2 * TIMEOUT + 20);
        eng_answers = 1;
        align_mid();
        chk("err_sticky", 32'(err_timeout), 32'd1);

        // ---------------- busy stall, then reset during WAIT ----------------
        nb = (cyc_n / REFRESH + 1) * REFRESH;
        while (cyc_n < nb - 5) cyc();
        clear_log();
        i2c_busy = 1'b1;
        while (cyc_n < nb + 15) cyc();
        chk("busy_no_start", 32'(q_cyc.size()), 32'd0);
        i2c_busy = 1'b0;
        cyc();
        chk("busy_start_cycle", 32'((q_cyc.size() > 0) ? q_cyc[0] : -1), 32'(nb + 15));
        chk("busy_start_low_after", 32'(i2c_start), 32'd0);
        chk("busy_line", 32'(i2c_line), 32'd2);
        chk("busy_d12", 32'(i2c_data12), 32'(exp_d12(0, sel)));
        repeat (4) cyc();
        rst_i = 1'b0;
        #1;
        check_reset_values("async_reset");
        done_cnt  = 0;
        i2c_done  = 1'b0;
        hv_enable = 1'b0;
        repeat (3) cyc();
        check_reset_values("reset_held");
        rst_i      = 1'b1;
        cyc_n      = 0;
        prev_start = 0;
        clear_log();
        while (cyc_n < REFRESH + 1) cyc();
        chk("no_start_after_reset", 32'(q_cyc.size()), 32'd0);
        cyc();
        chk("first_start_after_reset", 32'((q_cyc.size() > 0) ? q_cyc[0] : -1), 32'(REFRESH + 1));
        if (q_cyc.size() > 0) begin
            chk("first_start_line", 32'(q_line[0]), 32'd2);
        end
        repeat (50) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hv_dac_sequencer.md
HV_DAC_SEQUENCER -- requirements
Module: hv_dac_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 2: number of threshold DAC channels, 1..8.
REQ-002 SHALL have parameter DW, default 12: DAC code width.
REQ-003 SHALL have parameter HV_INIT, default 0: hv_current value after reset.
REQ-004 SHALL have parameter REFRESH, default 4194304: cycles between full refresh sweeps.
REQ-005 SHALL have parameter TIMEOUT, default 65535: maximum cycles to wait for i2c_done.
REQ-006 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port hv_enable  in  1  ramp toward target when high, toward 0 when low.
REQ-009 SHALL have ports hv_target, hv_limit  in  DW each  requested HV code and hard ceiling.
REQ-010 SHALL have port ramp_period  in  16  cycles per 1-LSB ramp step.
REQ-011 SHALL have port thresholds  in  NCH*DW  packed codes; channel k is at [k*DW +: DW].
REQ-012 SHALL have port eeprom_sel  in  3  DAC command/EEPROM select bits.
REQ-013 SHALL have ports i2c_busy, i2c_done  in  1 each  from the I2C engine; done is a 1-cycle pulse.
REQ-014 SHALL have port i2c_start  out  1  1-cycle transaction request.
REQ-015 SHALL have port i2c_line  out  2  bus select: 2 = threshold bus, 1 = HV bus.
REQ-016 SHALL have ports i2c_data12, i2c_data34  out  16 each  bytes 1-2 and bytes 3-4 of the write.
REQ-017 SHALL have port hv_current  out  DW  present ramped HV code.
REQ-018 SHALL have ports at_target, err_timeout  out  1 each  status; err_timeout is sticky.

Function
REQ-019 SHALL compute eff_target = min(hv_target, hv_limit) when hv_enable = 1, and 0 otherwise.
REQ-020 SHALL run a tick counter that pulses once every max(ramp_period,1) cycles; ramp_period = 0 acts as 1.
REQ-021 SHALL, on each tick, move hv_current by exactly ±1 toward eff_target and hold it when equal; no wrap below 0 or above 2^DW-1.
REQ-022 SHALL treat a hv_current above hv_limit, e.g. after hv_limit is lowered, as a ramp-down request with no jump.
REQ-023 SHALL drive at_target = (hv_current == eff_target), combinational from registered values.
REQ-024 SHALL set hv_dirty when hv_current changes and clear it when the HV slot is loaded.
REQ-025 SHALL implement the sequencer FSM: IDLE, LOAD, START, WAIT, NEXT.
REQ-026 SHALL move IDLE->LOAD on refresh counter expiry (full sweep, slot 0) or on hv_dirty (HV slot only); expiry wins if both occur.
REQ-027 SHALL use slots 0..NCH-1 for thresholds and slot NCH for HV.
REQ-028 SHALL in LOAD latch, for threshold slot k: line 2, data12 = {8'hC0 + 2k, eeprom_sel, 5'b0}, data34 = {thresholds[k], pad zeros to 16}.
REQ-029 SHALL in LOAD latch, for the HV slot: line 1, data12 = {8'hC0, eeprom_sel, 5'b0}, data34 = {hv_current, pad zeros to 16}.
REQ-030 SHALL keep i2c_line and i2c_data* stable from LOAD until leaving WAIT.
REQ-031 SHALL in START assert i2c_start for exactly 1 cycle when i2c_busy = 0, stall while busy, then go to WAIT.
REQ-032 SHALL go WAIT->NEXT on i2c_done; after TIMEOUT cycles without done it SHALL set err_timeout and go to NEXT.
REQ-033 SHALL go NEXT->LOAD with slot+1 in a sweep while slot < NCH; otherwise go to IDLE.
REQ-034 SHALL fix latency at refresh expiry/hv_dirty -> i2c_start = 2 cycles when not busy.
REQ-035 SHALL let ramp ticks continue during a transaction; a change then re-sets hv_dirty, causing a follow-up HV write.
REQ-036 SHALL keep the refresh counter free-running; an expiry during a sweep is held pending and serviced at IDLE.

Reset
REQ-037 SHALL on rst_i low asynchronously set: hv_current = HV_INIT; FSM = IDLE; slot, counters, hv_dirty, pending = 0; i2c_start = 0; i2c_line = 0; i2c_data* = 0; err_timeout = 0.
REQ-038 SHALL drop any in-flight transaction on reset with no i2c_start afterward; the first sweep follows the first refresh expiry.

Verification
REQ-039 SHALL test the ramp: HV_INIT = 0, target 10, limit 4000, ramp_period 4, enable -> hv_current = 10 after 40 cycles, then at_target = 1 and the value holds.
REQ-040 SHALL test the clamp: target 3000, limit 2000 -> hv_current stops at 2000; then limit = 1990 -> it steps down to 1990 at 1 LSB/tick.
REQ-041 SHALL test a sweep: NCH = 2, thresholds 2100/4000, eeprom 3, engine done 10 cycles after start -> three starts, with data12 0xC060, 0xC260, 0xC060, data34 0x8340, 0xFA00, hv_current<<4, and lines 2, 2, 1.
REQ-042 SHALL test the timeout: engine never returns done, TIMEOUT = 100 -> err_timeout = 1 at 100 cycles after start and the next slot still issues.
REQ-043 SHALL test the busy stall plus a mid-sweep reset: busy held 20 cycles -> start is delayed and is 1 cycle wide; rst_i low during WAIT -> all outputs go to reset values immediately.
